// File: rtl/reg_file_pkg.sv
// Shared opcodes, sequencer state encoding and default sizes for the
// register-file micro-sequencer.
package reg_file_pkg;

    localparam int DEF_WIDTH  = 9;
    localparam int DEF_ADDR_W = 2;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_MOV = 3'd1;
    localparam logic [2:0] OP_LI  = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_EXEC  = 2'd2,
        S_WRITE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/reg_file_alu.sv
// Combinational ALU for the sequencer. carry_valid flags the ops that own
// the carry/borrow flag (ADD and SUB).
module reg_file_alu
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             carry_valid_o,
    output logic             zero_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // Bit WIDTH of the widened difference is set exactly when a < b.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o      = '0;
        carry_o       = 1'b0;
        carry_valid_o = 1'b0;
        case (op_i)
            OP_MOV: result_o = a_i;
            OP_LI:  result_o = imm_i;
            OP_ADD: begin
                result_o      = sum[WIDTH-1:0];
                carry_o       = sum[WIDTH];
                carry_valid_o = 1'b1;
            end
            OP_SUB: begin
                result_o      = diff[WIDTH-1:0];
                carry_o       = diff[WIDTH];
                carry_valid_o = 1'b1;
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            default: result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/reg_file_seq.sv
// Four-state micro-sequencer: accepts one instruction, reads two registers,
// runs the ALU and writes the result back through the file's write port.
module reg_file_seq
    import reg_file_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] rd,
    input  logic [ADDR_W-1:0] rs0,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [WIDTH-1:0]  imm,
    output logic [ADDR_W-1:0] rf_rd0_addr,
    output logic [ADDR_W-1:0] rf_rd1_addr,
    input  logic [WIDTH-1:0]  rf_rd0_data,
    input  logic [WIDTH-1:0]  rf_rd1_data,
    output logic              rf_wr_en,
    output logic [ADDR_W-1:0] rf_wr_addr,
    output logic [WIDTH-1:0]  rf_wr_data,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic              carry,
    output logic              zero
);

    seq_state_e        state_q, state_d;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] rd_q;
    logic [WIDTH-1:0]  imm_q;
    logic [WIDTH-1:0]  a_q, b_q;
    logic [ADDR_W-1:0] rd0_addr_q, rd1_addr_q, wr_addr_q;
    logic [WIDTH-1:0]  wr_data_q, result_q;
    logic              carry_q, zero_q;

    logic [WIDTH-1:0]  alu_res;
    logic              alu_carry, alu_cv, alu_zero;

    reg_file_alu #(.WIDTH(WIDTH)) u_alu (
        .op_i          (op_q),
        .a_i           (a_q),
        .b_i           (b_q),
        .imm_i         (imm_q),
        .result_o      (alu_res),
        .carry_o       (alu_carry),
        .carry_valid_o (alu_cv),
        .zero_o        (alu_zero)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (instr_valid) state_d = S_READ;
            S_READ:  state_d = S_EXEC;
            S_EXEC:  state_d = S_WRITE;
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= OP_NOP;
            rd_q       <= '0;
            imm_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rd0_addr_q <= '0;
            rd1_addr_q <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            result_q   <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            state_q <= state_d;
            case (state_q)
                // Read addresses are loaded at accept so they are valid for all of READ.
                S_IDLE: if (instr_valid) begin
                    op_q       <= op;
                    rd_q       <= rd;
                    imm_q      <= imm;
                    rd0_addr_q <= rs0;
                    rd1_addr_q <= rs1;
                end
                S_READ: begin
                    a_q <= rf_rd0_data;
                    b_q <= rf_rd1_data;
                end
                S_EXEC: begin
                    wr_addr_q <= rd_q;
                    if (op_q != OP_NOP) begin
                        result_q  <= alu_res;
                        wr_data_q <= alu_res;
                        zero_q    <= alu_zero;
                        if (alu_cv) carry_q <= alu_carry;
                    end else begin
                        wr_data_q <= result_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign done        = (state_q == S_WRITE);
    assign rf_wr_en    = (state_q == S_WRITE) && (op_q != OP_NOP);
    assign rf_rd0_addr = rd0_addr_q;
    assign rf_rd1_addr = rd1_addr_q;
    assign rf_wr_addr  = wr_addr_q;
    assign rf_wr_data  = wr_data_q;
    assign result      = result_q;
    assign carry       = carry_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_reg_file_seq.sv
// Directed bench: sequencer plus a falling-edge-write register file model.
module tb_reg_file_seq;
    import reg_file_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [2:0] op = 3'd0;
    logic [1:0] rd = 2'd0, rs0 = 2'd0, rs1 = 2'd0;
    logic [8:0] imm = 9'd0;
    logic [1:0] rf_rd0_addr, rf_rd1_addr, rf_wr_addr;
    logic [8:0] rf_rd0_data, rf_rd1_data, rf_wr_data;
    logic       rf_wr_en, done, carry, zero;
    logic [8:0] result;

    logic [8:0] rf_mem [0:3];

    int checks = 0;
    int errors = 0;

    logic [2:0] t_op  [0:3];
    logic [1:0] t_rd  [0:3];
    logic [1:0] t_rs0 [0:3];
    logic [1:0] t_rs1 [0:3];
    logic [8:0] t_imm [0:3];
    int         acc   [0:3];
    int         k;
    logic       take;

    always #5 clk = ~clk;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rf_mem[i] <= 9'd0;
        end else if (rf_wr_en) begin
            rf_mem[rf_wr_addr] <= rf_wr_data;
        end
    end
    assign rf_rd0_data = rf_mem[rf_rd0_addr];
    assign rf_rd1_data = rf_mem[rf_rd1_addr];

    reg_file_seq #(.WIDTH(9), .ADDR_W(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op          (op),
        .rd          (rd),
        .rs0         (rs0),
        .rs1         (rs1),
        .imm         (imm),
        .rf_rd0_addr (rf_rd0_addr),
        .rf_rd1_addr (rf_rd1_addr),
        .rf_rd0_data (rf_rd0_data),
        .rf_rd1_data (rf_rd1_data),
        .rf_wr_en    (rf_wr_en),
        .rf_wr_addr  (rf_wr_addr),
        .rf_wr_data  (rf_wr_data),
        .done        (done),
        .result      (result),
        .carry       (carry),
        .zero        (zero)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction through all four states; caller sits 1 time unit after a posedge.
    task automatic issue(input string tag, input logic [2:0] o, input logic [1:0] d,
                         input logic [1:0] s0, input logic [1:0] s1, input logic [8:0] im,
                         input logic exp_we, input logic [8:0] exp_data);
        int n = 0;
        while (!instr_ready && n < 20) begin step(); n++; end
        chk({tag, " ready"}, 16'(instr_ready), 16'd1);
        op = o; rd = d; rs0 = s0; rs1 = s1; imm = im; instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        chk({tag, " busy"}, 16'(instr_ready), 16'd0);
        chk({tag, " rd0_addr"}, 16'(rf_rd0_addr), 16'(s0));
        chk({tag, " rd1_addr"}, 16'(rf_rd1_addr), 16'(s1));
        step();
        chk({tag, " no early done"}, 16'(done), 16'd0);
        step();
        chk({tag, " done"}, 16'(done), 16'd1);
        chk({tag, " wr_en"}, 16'(rf_wr_en), 16'(exp_we));
        if (exp_we) begin
            chk({tag, " wr_addr"}, 16'(rf_wr_addr), 16'(d));
            chk({tag, " wr_data"}, 16'(rf_wr_data), 16'(exp_data));
        end
        step();
        chk({tag, " done low"}, 16'(done), 16'd0);
        chk({tag, " ready back"}, 16'(instr_ready), 16'd1);
    endtask

    initial begin
        // Reset values
        repeat (2) step();
        chk("rst ready", 16'(instr_ready), 16'd1);
        chk("rst wr_en", 16'(rf_wr_en), 16'd0);
        chk("rst done", 16'(done), 16'd0);
        chk("rst rd0_addr", 16'(rf_rd0_addr), 16'd0);
        chk("rst wr_addr", 16'(rf_wr_addr), 16'd0);
        chk("rst wr_data", 16'(rf_wr_data), 16'd0);
        chk("rst result", 16'(result), 16'd0);
        chk("rst carry", 16'(carry), 16'd0);
        chk("rst zero", 16'(zero), 16'd1);
        rst = 1'b0;
        step();

        issue("li r1", OP_LI, 2'd1, 2'd0, 2'd0, 9'd13, 1'b1, 9'd13);
        chk("li r1 value", 16'(rf_mem[1]), 16'd13);
        chk("li r1 zero", 16'(zero), 16'd0);

        issue("li r0", OP_LI, 2'd0, 2'd0, 2'd0, 9'd117, 1'b1, 9'd117);
        issue("li r1b", OP_LI, 2'd1, 2'd0, 2'd0, 9'd13, 1'b1, 9'd13);
        issue("add", OP_ADD, 2'd2, 2'd0, 2'd1, 9'd0, 1'b1, 9'd130);
        chk("add r2", 16'(rf_mem[2]), 16'd130);
        chk("add carry", 16'(carry), 16'd0);
        issue("sub", OP_SUB, 2'd3, 2'd1, 2'd0, 9'd0, 1'b1, 9'd408);
        chk("sub r3", 16'(rf_mem[3]), 16'd408);
        chk("sub borrow", 16'(carry), 16'd1);
        chk("sub zero", 16'(zero), 16'd0);

        issue("li 511", OP_LI, 2'd0, 2'd0, 2'd0, 9'd511, 1'b1, 9'd511);
        issue("li 1", OP_LI, 2'd1, 2'd0, 2'd0, 9'd1, 1'b1, 9'd1);
        issue("add wrap", OP_ADD, 2'd2, 2'd0, 2'd1, 9'd0, 1'b1, 9'd0);
        chk("wrap r2", 16'(rf_mem[2]), 16'd0);
        chk("wrap carry", 16'(carry), 16'd1);
        chk("wrap zero", 16'(zero), 16'd1);

        // NOP between writes: no write, flags and result held
        issue("nop", OP_NOP, 2'd0, 2'd2, 2'd3, 9'd77, 1'b0, 9'd0);
        chk("nop r0 kept", 16'(rf_mem[0]), 16'd511);
        chk("nop carry", 16'(carry), 16'd1);
        chk("nop zero", 16'(zero), 16'd1);
        chk("nop result", 16'(result), 16'd0);
        issue("li after nop", OP_LI, 2'd2, 2'd0, 2'd0, 9'd3, 1'b1, 9'd3);
        chk("li after nop carry", 16'(carry), 16'd1);

        // instr_valid held high over four instructions
        t_op[0] = OP_LI;  t_rd[0] = 2'd0; t_rs0[0] = 2'd0; t_rs1[0] = 2'd0; t_imm[0] = 9'd5;
        t_op[1] = OP_LI;  t_rd[1] = 2'd1; t_rs0[1] = 2'd0; t_rs1[1] = 2'd0; t_imm[1] = 9'd7;
        t_op[2] = OP_ADD; t_rd[2] = 2'd2; t_rs0[2] = 2'd0; t_rs1[2] = 2'd1; t_imm[2] = 9'd0;
        t_op[3] = OP_XOR; t_rd[3] = 2'd3; t_rs0[3] = 2'd2; t_rs1[3] = 2'd0; t_imm[3] = 9'd0;
        k = 0;
        op = t_op[0]; rd = t_rd[0]; rs0 = t_rs0[0]; rs1 = t_rs1[0]; imm = t_imm[0];
        instr_valid = 1'b1;
        for (int cyc = 0; cyc < 30 && k < 4; cyc++) begin
            take = instr_ready;
            if (take) begin
                acc[k] = cyc;
                chk("idle no write", 16'(rf_wr_en), 16'd0);
            end
            step();
            if (take) begin
                k++;
                if (k < 4) begin
                    op = t_op[k]; rd = t_rd[k]; rs0 = t_rs0[k]; rs1 = t_rs1[k]; imm = t_imm[k];
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        chk("stream accepts", 16'(k), 16'd4);
        for (int i = 1; i < 4; i++) chk("stream spacing", 16'(acc[i] - acc[i-1]), 16'd4);
        repeat (4) step();
        chk("stream r2", 16'(rf_mem[2]), 16'd12);
        chk("stream r3", 16'(rf_mem[3]), 16'd9);
        chk("stream carry", 16'(carry), 16'd0);

        // Reset during EXEC of ADD r3 drops the instruction
        op = OP_ADD; rd = 2'd3; rs0 = 2'd0; rs1 = 2'd1; imm = 9'd0;
        chk("rst-mid ready", 16'(instr_ready), 16'd1);
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("rst-mid ready async", 16'(instr_ready), 16'd1);
        chk("rst-mid wr_en", 16'(rf_wr_en), 16'd0);
        chk("rst-mid done", 16'(done), 16'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst-mid held wr_en", 16'(rf_wr_en), 16'd0);
            chk("rst-mid held done", 16'(done), 16'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post-rst done", 16'(done), 16'd0);
        end
        chk("post-rst ready", 16'(instr_ready), 16'd1);
        chk("post-rst r3", 16'(rf_mem[3]), 16'd0);
        chk("post-rst zero", 16'(zero), 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
